// File: rtl/elink_pkg.sv
// rtl/elink_pkg.sv - shared eLink TX constants, FSM state encoding and header packing
package elink_pkg;

  localparam logic [1:0] DM_DOUBLE  = 2'b11;

  localparam logic [7:0] FRAME_HDR  = 8'h3F;
  localparam logic [7:0] FRAME_DATA = 8'hFF;
  localparam logic [7:0] FRAME_IDLE = 8'h00;

  localparam int B0_LSB = 40;
  localparam int B1_LSB = 32;
  localparam int B4_LSB = 8;
  localparam int B5_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } tx_state_t;

  // B2..B4 carry dst[27:4] as one contiguous 24-bit field ending at B4
  function automatic logic [63:0] make_header(input logic        write,
                                              input logic        inc,
                                              input logic [1:0]  datamode,
                                              input logic [3:0]  ctrlmode,
                                              input logic [31:0] dst);
    logic [63:0] h;
    h               = '0;
    h[B0_LSB +: 8]  = {~write, inc, 6'd0};
    h[B1_LSB +: 8]  = {ctrlmode, dst[31:28]};
    h[B4_LSB +: 24] = dst[27:4];
    h[B5_LSB +: 8]  = {dst[3:0], datamode, write, 1'b1};
    return h;
  endfunction

endpackage

// File: rtl/etx_protocol_burst_if.sv
// rtl/etx_protocol_burst_if.sv - eMesh transaction handshake between TX arbiter and encoder
interface etx_protocol_burst_if;
  logic        etx_access;
  logic        etx_write;
  logic [1:0]  etx_datamode;
  logic [3:0]  etx_ctrlmode;
  logic [31:0] etx_dstaddr;
  logic [31:0] etx_srcaddr;
  logic [31:0] etx_data;
  logic        etx_ack;

  modport master (
    output etx_access, etx_write, etx_datamode, etx_ctrlmode,
           etx_dstaddr, etx_srcaddr, etx_data,
    input  etx_ack
  );

  modport slave (
    input  etx_access, etx_write, etx_datamode, etx_ctrlmode,
           etx_dstaddr, etx_srcaddr, etx_data,
    output etx_ack
  );
endinterface

// File: rtl/etx_wait_sync.sv
// rtl/etx_wait_sync.sv - multi-flop synchronizer for link wait inputs, async active-low clear
module etx_wait_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/etx_protocol_burst.sv
// rtl/etx_protocol_burst.sv - eLink TX protocol encoder with sequential double-write burst merging
module etx_protocol_burst
  import elink_pkg::*;
#(
  parameter int BURST_EN    = 1,
  parameter int MAX_BURST   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 tx_lclk_par,
  input  logic                 nreset,
  etx_protocol_burst_if.slave  etx,
  output logic                 etx_rd_wait,
  output logic                 etx_wr_wait,
  output logic [7:0]           tx_frame_par,
  output logic [63:0]          tx_data_par,
  input  logic                 tx_rd_wait,
  input  logic                 tx_wr_wait,
  output logic [1:0]           ecfg_tx_datain,
  output logic                 burst_active
);

  localparam logic [8:0] MAX_CNT = 9'(MAX_BURST);

  tx_state_t   state, state_d;
  logic        cap_write;
  logic [1:0]  cap_datamode;
  logic [3:0]  cap_ctrlmode;
  logic [31:0] cap_dst, cap_src, cap_data;
  logic [8:0]  beat_cnt, cnt_d;
  logic [7:0]  frame_d;
  logic [63:0] data_d;
  logic        burst_d, load, ack;
  logic        blocked, inc_in, cap_inc, burst_match;

  etx_wait_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(tx_lclk_par), .rst_n(nreset), .d(tx_rd_wait), .q(etx_rd_wait)
  );

  etx_wait_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(tx_lclk_par), .rst_n(nreset), .d(tx_wr_wait), .q(etx_wr_wait)
  );

  assign ecfg_tx_datain = {etx_wr_wait, etx_rd_wait};
  assign blocked        = etx.etx_write ? etx_wr_wait : etx_rd_wait;
  assign inc_in         = (BURST_EN != 0) && etx.etx_write && (etx.etx_datamode == DM_DOUBLE);
  assign cap_inc        = (BURST_EN != 0) && cap_write && (cap_datamode == DM_DOUBLE);

  // 33-bit compare rejects a successor address that only matches after wrapping
  assign burst_match = etx.etx_access && !etx_wr_wait && cap_inc &&
                       etx.etx_write && (etx.etx_datamode == DM_DOUBLE) &&
                       (etx.etx_ctrlmode == cap_ctrlmode) &&
                       ({1'b0, etx.etx_dstaddr} == ({1'b0, cap_dst} + 33'd8)) &&
                       (beat_cnt < MAX_CNT);

  // ack is held low while reset is asserted even though the FSM sits in IDLE
  assign etx.etx_ack = ack & nreset;

  always_ff @(posedge tx_lclk_par or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (ack) state_d = HDR;
      HDR:     state_d = DATA;
      DATA:    if (!burst_match) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack     = 1'b0;
    load    = 1'b0;
    frame_d = FRAME_IDLE;
    data_d  = '0;
    burst_d = 1'b0;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        ack = etx.etx_access && !blocked;
        if (ack) begin
          load    = 1'b1;
          frame_d = FRAME_HDR;
          data_d  = make_header(etx.etx_write, inc_in, etx.etx_datamode,
                                etx.etx_ctrlmode, etx.etx_dstaddr);
        end
      end
      HDR: begin
        frame_d = FRAME_DATA;
        data_d  = {cap_data, cap_src};
        cnt_d   = 9'd1;
      end
      DATA: begin
        ack = burst_match;
        if (burst_match) begin
          load    = 1'b1;
          frame_d = FRAME_DATA;
          data_d  = {etx.etx_data, etx.etx_srcaddr};
          burst_d = 1'b1;
          cnt_d   = beat_cnt + 9'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_lclk_par or negedge nreset) begin
    if (!nreset) begin
      tx_frame_par <= FRAME_IDLE;
      tx_data_par  <= '0;
      burst_active <= 1'b0;
      beat_cnt     <= '0;
      cap_write    <= 1'b0;
      cap_datamode <= '0;
      cap_ctrlmode <= '0;
      cap_dst      <= '0;
      cap_src      <= '0;
      cap_data     <= '0;
    end else begin
      tx_frame_par <= frame_d;
      tx_data_par  <= data_d;
      burst_active <= burst_d;
      beat_cnt     <= cnt_d;
      if (load) begin
        cap_write    <= etx.etx_write;
        cap_datamode <= etx.etx_datamode;
        cap_ctrlmode <= etx.etx_ctrlmode;
        cap_dst      <= etx.etx_dstaddr;
        cap_src      <= etx.etx_srcaddr;
        cap_data     <= etx.etx_data;
      end
    end
  end

endmodule

// File: tb/tb_etx_protocol_burst.sv
// tb/tb_etx_protocol_burst.sv - scoreboard bench for etx_protocol_burst
module tb_etx_protocol_burst;

  localparam int TB_MAX  = 4;
  localparam int TB_SYNC = 2;

  typedef struct packed {
    logic        write;
    logic [1:0]  dm;
    logic [3:0]  ctrl;
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] data;
  } tx_t;

  typedef struct packed {
    logic [7:0]  frame;
    logic [63:0] data;
    logic        burst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_rd_wait = 1'b0;
  logic        tx_wr_wait = 1'b0;
  logic        etx_rd_wait, etx_wr_wait, burst_active;
  logic [7:0]  tx_frame_par;
  logic [63:0] tx_data_par;
  logic [1:0]  ecfg_tx_datain;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   m_open = 1'b0;
  int   m_beats = 0;
  tx_t  m_last = '0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_frame = 8'h00;
  exp_t mon_e, mon_o;

  etx_protocol_burst_if bus();

  etx_protocol_burst #(.BURST_EN(1), .MAX_BURST(TB_MAX), .SYNC_STAGES(TB_SYNC)) dut (
    .tx_lclk_par(clk), .nreset(rst_n), .etx(bus),
    .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait),
    .tx_frame_par(tx_frame_par), .tx_data_par(tx_data_par),
    .tx_rd_wait(tx_rd_wait), .tx_wr_wait(tx_wr_wait),
    .ecfg_tx_datain(ecfg_tx_datain), .burst_active(burst_active)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic tx_t mk(input logic w, input logic [1:0] dm, input logic [3:0] c,
                             input logic [31:0] dst, input logic [31:0] src, input logic [31:0] data);
    return {w, dm, c, dst, src, data};
  endfunction

  function automatic logic [47:0] hdr(input tx_t t);
    logic inc;
    inc = t.write && (t.dm == 2'b11);
    return {~t.write, inc, 6'd0, t.ctrl, t.dst[31:28], t.dst[27:4], t.dst[3:0], t.dm, t.write, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_tx(input tx_t t);
    logic [32:0] nxt;
    nxt = {1'b0, m_last.dst} + 33'd8;
    if (m_open && m_last.write && m_last.dm == 2'b11 && t.write && t.dm == 2'b11 &&
        t.ctrl == m_last.ctrl && nxt == {1'b0, t.dst} && m_beats < TB_MAX) begin
      q.push_back({8'hFF, t.data, t.src, 1'b1});
      m_beats++;
    end else begin
      if (m_open) q.push_back({8'h00, 64'd0, 1'b0});
      q.push_back({8'h3F, 16'd0, hdr(t), 1'b0});
      q.push_back({8'hFF, t.data, t.src, 1'b0});
      m_open  = 1'b1;
      m_beats = 1;
    end
    m_last = t;
  endtask

  task automatic push_end();
    if (m_open) q.push_back({8'h00, 64'd0, 1'b0});
    m_open = 1'b0;
  endtask

  task automatic drive(input tx_t t);
    bus.etx_access   = 1'b1;
    bus.etx_write    = t.write;
    bus.etx_datamode = t.dm;
    bus.etx_ctrlmode = t.ctrl;
    bus.etx_dstaddr  = t.dst;
    bus.etx_srcaddr  = t.src;
    bus.etx_data     = t.data;
  endtask

  task automatic send(input tx_t t, input string tag);
    bit got;
    got = 1'b0;
    push_tx(t);
    drive(t);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.etx_ack === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    assert (got === 1'b1) else begin
      errors++;
      $error("FAIL %s_ack: observed no ack expected ack within 40 cycles", tag);
    end
  endtask

  task automatic idle(input int n);
    bus.etx_access = 1'b0;
    push_end();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every word of a frame, and the 00 word that closes it, is scored in order
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_frame = 8'h00;
    end else begin
      if (tx_frame_par !== 8'h00 || prev_frame !== 8'h00) begin
        mon_o = {tx_frame_par, tx_data_par, burst_active};
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL mon_unexpected: observed frame=%h data=%h expected no output", tx_frame_par, tx_data_par);
        end
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          checks++;
          assert (mon_o === mon_e) else begin
            errors++;
            $error("FAIL mon_word: observed frame=%h data=%h burst=%b expected frame=%h data=%h burst=%b",
                   mon_o.frame, mon_o.data, mon_o.burst, mon_e.frame, mon_e.data, mon_e.burst);
          end
        end
      end
      prev_frame = tx_frame_par;
    end
  end

  initial begin
    drive(mk(1'b1, 2'b10, 4'h0, 32'h0, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    chk("rst_frame", 64'(tx_frame_par), 64'h0);
    chk("rst_data", tx_data_par, 64'h0);
    chk("rst_ack", 64'(bus.etx_ack), 64'h0);
    chk("rst_burst", 64'(burst_active), 64'h0);
    chk("rst_ecfg", 64'(ecfg_tx_datain), 64'h0);
    bus.etx_access = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    send(mk(1'b1, 2'b10, 4'h0, 32'h8080_0010, 32'h1234_5678, 32'hDEAD_BEEF), "single_wr");
    idle(3);

    send(mk(1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0, 32'h0), "read_a");
    send(mk(1'b0, 2'b10, 4'h0, 32'h0000_0108, 32'h0, 32'h0), "read_b");
    idle(4);

    for (int i = 0; i < 4; i++)
      send(mk(1'b1, 2'b11, 4'h2, 32'h1000 + 32'(i * 8), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)), "burst4");
    idle(4);

    send(mk(1'b1, 2'b11, 4'h0, 32'h5018, 32'h1, 32'h2), "brk_a");
    send(mk(1'b1, 2'b11, 4'h0, 32'h5020, 32'h3, 32'h4), "brk_b");
    send(mk(1'b1, 2'b11, 4'h0, 32'h5030, 32'h5, 32'h6), "brk_c");
    idle(4);

    send(mk(1'b1, 2'b11, 4'h1, 32'h6000, 32'h7, 32'h8), "ctrl_a");
    send(mk(1'b1, 2'b11, 4'h2, 32'h6008, 32'h9, 32'hA), "ctrl_b");
    send(mk(1'b1, 2'b11, 4'h0, 32'hFFFF_FFF8, 32'hB, 32'hC), "carry_a");
    send(mk(1'b1, 2'b11, 4'h0, 32'h0000_0000, 32'hD, 32'hE), "carry_b");
    idle(4);

    for (int i = 0; i < 6; i++)
      send(mk(1'b1, 2'b11, 4'h3, 32'h7000 + 32'(i * 8), 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)), "max_burst");
    idle(4);

    tx_rd_wait = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_sync_stage1", 64'(etx_rd_wait), 64'h0);
    @(negedge clk);
    chk("rd_sync_stage2", 64'(etx_rd_wait), 64'h1);
    chk("ecfg_rd", 64'(ecfg_tx_datain), 64'h1);
    drive(mk(1'b0, 2'b10, 4'h0, 32'h200, 32'h0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_blocked_ack", 64'(bus.etx_ack), 64'h0);
    end
    @(posedge clk); #1;
    send(mk(1'b1, 2'b10, 4'h0, 32'h300, 32'h11, 32'h22), "wr_during_rd_wait");
    idle(2);
    tx_rd_wait = 1'b0;
    repeat (4) @(posedge clk); #1;

    send(mk(1'b1, 2'b11, 4'h0, 32'h9000, 32'h31, 32'h32), "wr_wait_a");
    tx_wr_wait = 1'b1;
    send(mk(1'b1, 2'b11, 4'h0, 32'h9008, 32'h33, 32'h34), "wr_wait_b");
    push_end();
    drive(mk(1'b1, 2'b11, 4'h0, 32'h9010, 32'h35, 32'h36));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_wait_hold_ack", 64'(bus.etx_ack), 64'h0);
    end
    chk("wr_wait_sync", 64'(etx_wr_wait), 64'h1);
    chk("ecfg_wr", 64'(ecfg_tx_datain), 64'h2);
    @(posedge clk); #1;
    tx_wr_wait = 1'b0;
    send(mk(1'b1, 2'b11, 4'h0, 32'h9010, 32'h35, 32'h36), "wr_wait_c");
    idle(4);

    send(mk(1'b1, 2'b11, 4'h0, 32'h3000, 32'h41, 32'h42), "rst_mid_a");
    send(mk(1'b1, 2'b11, 4'h0, 32'h3008, 32'h43, 32'h44), "rst_mid_b");
    mon_en = 1'b0;
    drive(mk(1'b1, 2'b10, 4'h0, 32'h3100, 32'h0, 32'h0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_frame", 64'(tx_frame_par), 64'h0);
    chk("rst_mid_data", tx_data_par, 64'h0);
    chk("rst_mid_ack", 64'(bus.etx_ack), 64'h0);
    chk("rst_mid_burst", 64'(burst_active), 64'h0);
    q.delete();
    m_open = 1'b0;
    @(negedge clk);
    bus.etx_access = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(mk(1'b1, 2'b10, 4'h5, 32'h4444_0008, 32'h5555_6666, 32'h7777_8888), "post_rst");
    idle(6);

    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
